fwd_ctrl: RTL

- Operand-forwarding and load-use hazard control for the 5-stage RV32I pipeline.
- Tracks destination records of instructions in the MEM and WB stages.
- Compares those records against the EX-stage source registers and drives the one-hot selects of the two EX operand 3:1 muxes.
- Mux inputs: regfile data (sel[0]), MEM-stage ALU result (sel[1]), WB-stage result (sel[2]).
- Raises a load-use stall when a dependent load is still in MEM.

---
 rtl/fwd_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard control for the 5-stage RV32I pipeline.
// Optional load-use stall counter enabled by defining FWD_CTRL_PERF_CNT_EN.
`timescale 1ns/1ps

module fwd_ctrl #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic              ex_rs1_en,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_rs2_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_is_load,
  output logic [2:0]        sel1,
  output logic [2:0]        sel2,
  output logic              ld_use_stall
`ifdef FWD_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

  localparam logic [2:0] SEL_RF  = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_WB  = 3'b100;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } rec_t;

  rec_t mem_rec;
  rec_t wb_rec;

  logic mem_hit1, mem_hit2;
  logic wb_hit1, wb_hit2;

  function automatic logic hit(input rec_t rec, input logic [REG_AW-1:0] rs,
                               input logic rs_en, input logic vld);
    return rec.valid && rec.we && (rec.rd == rs) && (rs != ZERO_IDX) && rs_en && vld;
  endfunction

  // A MEM-stage load cannot forward yet; the stall covers it, so fall back to
  // the regfile path to keep the select one-hot.
  function automatic logic [2:0] pick(input logic m_hit, input logic w_hit,
                                      input logic m_load);
    if (m_hit)
      return m_load ? SEL_RF : SEL_MEM;
    else if (w_hit)
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    mem_hit1     = hit(mem_rec, ex_rs1, ex_rs1_en, ex_valid);
    mem_hit2     = hit(mem_rec, ex_rs2, ex_rs2_en, ex_valid);
    wb_hit1      = hit(wb_rec,  ex_rs1, ex_rs1_en, ex_valid);
    wb_hit2      = hit(wb_rec,  ex_rs2, ex_rs2_en, ex_valid);
    sel1         = pick(mem_hit1, wb_hit1, mem_rec.is_load);
    sel2         = pick(mem_hit2, wb_hit2, mem_rec.is_load);
    ld_use_stall = mem_rec.is_load && (mem_hit1 || mem_hit2);
  end

  // NOTE: state uses non-blocking assignments so WB samples the old MEM
  // record on the same edge MEM is overwritten.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem_rec <= '0;
      wb_rec  <= '0;
    end else if (!hold) begin
      wb_rec <= mem_rec;
      if (ld_use_stall)
        mem_rec <= '0;
      else
        mem_rec <= '{valid: ex_valid, rd: ex_rd, we: ex_we, is_load: ex_is_load};
    end
  end

`ifdef FWD_CTRL_PERF_CNT_EN
  // Saturating count of stall cycles that actually advance the pipeline.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (ld_use_stall && !hold && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
